// File: rtl/uart_txblock_if.sv
// Handshake and serial-line bundle for uart_txblock; master is the byte
// source, slave is the transmitter.
interface uart_txblock_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] para_data_in;
    logic                 serial_data_out;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output para_data_in,
        input  serial_data_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  para_data_in,
        output serial_data_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_txblock.sv
// UART transmitter on the 16x clock: start bit, LSB-first data, optional even
// parity (define UART_TX_PARITY_EN), one stop bit.
module uart_txblock #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic              clk16,
    input  logic              rst,
    uart_txblock_if.slave     tx_if
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] sh_q;
    logic                 line_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cnt_last;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk16) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_if.tx_start) begin
                        sh_q    <= tx_if.para_data_in;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= START;
                        line_q  <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^tx_if.para_data_in;
`endif
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                        line_q  <= sh_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        sh_q  <= {1'b0, sh_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            line_q  <= par_q;
`else
                            state_q <= STOP;
                            line_q  <= 1'b1;
`endif
                        end else begin
                            // line takes the next bit now, since the shift lands on this same edge
                            idx_q  <= idx_q + 1'b1;
                            line_q <= sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        line_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    line_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.serial_data_out = line_q;
    assign tx_if.tx_busy         = busy_q;
    assign tx_if.tx_done         = done_q;
endmodule
